// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads take priority, host writes are
// queued in a small FIFO and get a forced slot when starved for too long.
module fb_arbiter #(
    parameter int unsigned AW       = 13,
    parameter int unsigned DW       = 12,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          host_valid,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    starve_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    state_t        state;
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_next;
    logic          fifo_empty;
    logic          push;
    logic          host_pop;
    logic          force_next;

    assign fifo_empty = (fifo_count == '0);
    assign host_ready = (fifo_count < CW'(DEPTH));
    assign push       = host_valid & host_ready;
    assign disp_rdata = mem_rdata;

    // Slot decision: display wins in NORMAL; FORCE hands the cycle to the host FIFO.
    always_comb begin
        disp_gnt = 1'b0;
        host_pop = 1'b0;
        if (state == ST_FORCE) begin
            host_pop = !fifo_empty;
        end else begin
            disp_gnt = disp_req;
            host_pop = !disp_req && !fifo_empty;
        end
    end

    // Starvation timer for the FIFO head.
    always_comb begin
        wait_next = '0;
        if (host_pop || fifo_empty) begin
            wait_next = '0;
        end else if (wait_cnt >= WW'(MAX_WAIT)) begin
            wait_next = WW'(MAX_WAIT);
        end else begin
            wait_next = wait_cnt + WW'(1);
        end
    end

    assign force_next = (state == ST_NORMAL) && (wait_next == WW'(MAX_WAIT));

    // Memory port mux; idle cycles drive zeros.
    always_comb begin
        mem_en    = disp_gnt | host_pop;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_pop) begin
            mem_we    = 1'b1;
            mem_addr  = fifo_addr[rd_ptr];
            mem_wdata = fifo_data[rd_ptr];
        end else if (disp_gnt) begin
            mem_addr  = disp_addr;
        end
    end

    // Arbiter state, counters and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_NORMAL;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
            disp_rvalid <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            state       <= force_next ? ST_FORCE : ST_NORMAL;
            wait_cnt    <= wait_next;
            disp_rvalid <= disp_gnt;
            if ((state == ST_FORCE) && (starve_cnt != 8'hFF)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (host_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, host_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_addr;
            fifo_data[wr_ptr] <= host_wdata;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter: vector table plus starvation,
// saturation and mid-operation reset sequences.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic        disp_gnt;
    logic        disp_rvalid;
    logic [11:0] disp_rdata;
    logic        host_valid;
    logic [12:0] host_addr;
    logic [11:0] host_wdata;
    logic        host_ready;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [7:0]  starve_cnt;

    int checks   = 0;
    int failures = 0;

    fb_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, data is a fixed function of address.
    always @(posedge clk) begin
        mem_rdata <= (mem_en && !mem_we) ? (12'(mem_addr) ^ 12'hA5A) : 12'h000;
    end

    typedef struct {
        logic        dr;
        logic [12:0] da;
        logic        hv;
        logic [12:0] ha;
        logic [11:0] hd;
        logic        gnt;
        logic        rdy;
        logic        en;
        logic        we;
        logic [12:0] ma;
        logic [11:0] mwd;
        logic        rv;
        logic [11:0] rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic dr, logic [12:0] da, logic hv, logic [12:0] ha,
                                logic [11:0] hd, logic gnt, logic rdy, logic en, logic we,
                                logic [12:0] ma, logic [11:0] mwd, logic rv, logic [11:0] rd);
        vec_t v;
        v.dr = dr; v.da = da; v.hv = hv; v.ha = ha; v.hd = hd;
        v.gnt = gnt; v.rdy = rdy; v.en = en; v.we = we;
        v.ma = ma; v.mwd = mwd; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    int forces;
    int c;
    bit any_write;

    initial begin
        rst = 1'b1; disp_req = 1'b0; disp_addr = '0;
        host_valid = 1'b0; host_addr = '0; host_wdata = '0;
        #3;
        chk("rst host_ready", 32'(host_ready), 32'd1);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst disp_gnt", 32'(disp_gnt), 32'd0);
        chk("rst disp_rvalid", 32'(disp_rvalid), 32'd0);
        chk("rst starve_cnt", 32'(starve_cnt), 32'd0);
        cycle(); cycle();
        rst = 1'b0;

        // Host-only writes: each drains one cycle after its push.
        vq.push_back(mk(0, 0, 1, 13'h1, 12'h111, 0, 1, 0, 0, 13'h0, 12'h000, 0, 12'h0));
        vq.push_back(mk(0, 0, 1, 13'h2, 12'h222, 0, 1, 1, 1, 13'h1, 12'h111, 0, 12'h0));
        vq.push_back(mk(0, 0, 1, 13'h3, 12'h333, 0, 1, 1, 1, 13'h2, 12'h222, 0, 12'h0));
        vq.push_back(mk(0, 0, 0, 13'h0, 12'h000, 0, 1, 1, 1, 13'h3, 12'h333, 0, 12'h0));
        vq.push_back(mk(0, 0, 0, 13'h0, 12'h000, 0, 1, 0, 0, 13'h0, 12'h000, 0, 12'h0));
        // Display-only scan of addresses 0..9.
        for (int k = 0; k < 10; k++) begin
            vq.push_back(mk(1, 13'(k), 0, 13'h0, 12'h000, 1, 1, 1, 0, 13'(k), 12'h000,
                            (k > 0), 12'(k - 1) ^ 12'hA5A));
        end
        vq.push_back(mk(0, 0, 0, 13'h0, 12'h000, 0, 1, 0, 0, 13'h0, 12'h000, 1, 12'h009 ^ 12'hA5A));
        // FIFO fill behind a continuous display stream, then drain.
        for (int k = 0; k < 4; k++) begin
            vq.push_back(mk(1, 13'h14, 1, 13'h100 + 13'(k), 12'hA00 + 12'(k), 1, 1, 1, 0, 13'h14,
                            12'h000, (k > 0), 12'h014 ^ 12'hA5A));
        end
        vq.push_back(mk(1, 13'h14, 1, 13'h104, 12'hA04, 1, 0, 1, 0, 13'h14, 12'h000, 1, 12'h014 ^ 12'hA5A));
        vq.push_back(mk(1, 13'h14, 1, 13'h104, 12'hA04, 1, 0, 1, 0, 13'h14, 12'h000, 1, 12'h014 ^ 12'hA5A));
        vq.push_back(mk(0, 13'h14, 1, 13'h104, 12'hA04, 0, 0, 1, 1, 13'h100, 12'hA00, 1, 12'h014 ^ 12'hA5A));
        vq.push_back(mk(0, 13'h0, 1, 13'h104, 12'hA04, 0, 1, 1, 1, 13'h101, 12'hA01, 0, 12'h0));
        for (int k = 2; k < 5; k++) begin
            vq.push_back(mk(0, 13'h0, 0, 13'h0, 12'h000, 0, 1, 1, 1, 13'h100 + 13'(k),
                            12'hA00 + 12'(k), 0, 12'h0));
        end
        vq.push_back(mk(0, 0, 0, 13'h0, 12'h000, 0, 1, 0, 0, 13'h0, 12'h000, 0, 12'h0));

        foreach (vq[i]) begin
            disp_req = vq[i].dr; disp_addr = vq[i].da;
            host_valid = vq[i].hv; host_addr = vq[i].ha; host_wdata = vq[i].hd;
            #2;
            chk($sformatf("row%0d disp_gnt", i), 32'(disp_gnt), 32'(vq[i].gnt));
            chk($sformatf("row%0d host_ready", i), 32'(host_ready), 32'(vq[i].rdy));
            chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(vq[i].en));
            chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vq[i].we));
            chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vq[i].ma));
            if (!vq[i].en || vq[i].we)
                chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(vq[i].mwd));
            chk($sformatf("row%0d disp_rvalid", i), 32'(disp_rvalid), 32'(vq[i].rv));
            if (vq[i].rv)
                chk($sformatf("row%0d disp_rdata", i), 32'(disp_rdata), 32'(vq[i].rd));
            cycle();
        end

        // Starvation: one write behind a continuous display stream.
        disp_req = 1'b1; disp_addr = 13'h5;
        host_valid = 1'b1; host_addr = 13'h55; host_wdata = 12'h5A5;
        #2;
        chk("starve push ready", 32'(host_ready), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            cycle();
            host_valid = 1'b0;
            #2;
            chk($sformatf("starve deny%0d gnt/we", i), 32'({disp_gnt, mem_we}), 32'h2);
        end
        cycle(); #2;
        chk("force disp_gnt", 32'(disp_gnt), 32'd0);
        chk("force mem_we", 32'(mem_we), 32'd1);
        chk("force mem_addr", 32'(mem_addr), 32'h55);
        chk("force mem_wdata", 32'(mem_wdata), 32'h5A5);
        chk("force starve_cnt before", 32'(starve_cnt), 32'd0);
        cycle(); #2;
        chk("after force disp_gnt", 32'(disp_gnt), 32'd1);
        chk("after force starve_cnt", 32'(starve_cnt), 32'd1);

        // Saturation: host held busy behind display until 300 more forced slots.
        host_valid = 1'b1; host_addr = 13'h77; host_wdata = 12'h777;
        forces = 0;
        for (c = 0; c < 6000 && forces < 300; c++) begin
            cycle(); #2;
            if (forces == 100) chk("sat starve@100", 32'(starve_cnt), 32'd101);
            if (forces == 253) chk("sat starve@253", 32'(starve_cnt), 32'd254);
            if (forces == 254) chk("sat starve@254", 32'(starve_cnt), 32'd255);
            if (!disp_gnt) forces++;
        end
        chk("sat forced slots reached", 32'(forces), 32'd300);
        cycle(); #2;
        chk("sat starve_cnt", 32'(starve_cnt), 32'd255);
        for (int i = 0; i < 40; i++) cycle();
        #2;
        chk("sat starve_cnt holds", 32'(starve_cnt), 32'd255);

        // Drain, then reset with two entries queued and a read return pending.
        disp_req = 1'b0; host_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        disp_req = 1'b1; disp_addr = 13'h3;
        host_valid = 1'b1; host_addr = 13'h10; host_wdata = 12'h001;
        cycle();
        host_addr = 13'h11; host_wdata = 12'h002;
        cycle();
        host_valid = 1'b0;
        #2;
        chk("pre-reset disp_rvalid", 32'(disp_rvalid), 32'd1);
        disp_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("async rst host_ready", 32'(host_ready), 32'd1);
        chk("async rst mem_en", 32'(mem_en), 32'd0);
        chk("async rst disp_rvalid", 32'(disp_rvalid), 32'd0);
        chk("async rst starve_cnt", 32'(starve_cnt), 32'd0);
        cycle(); cycle();
        rst = 1'b0;
        any_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (mem_en) any_write = 1'b1;
            cycle();
        end
        chk("no mem access after reset", 32'(any_write), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
